// File: rtl/dshot_frame_rx.sv
// DShot frame receiver: synchronizes the raw line, measures high pulses,
// assembles 16-bit frames, checks the CRC and maintains a failsafe link flag.
module dshot_frame_rx #(
  parameter int CLK_PER_BIT_THRESH = 60,
  parameter int MIN_HIGH           = 16,
  parameter int MAX_HIGH           = 100,
  parameter int GAP_TIMEOUT        = 200,
  parameter int FAILSAFE_CYC       = 1600000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dshotPin,
  output logic [10:0] throttle,
  output logic        telem,
  output logic [7:0]  outputSpeed,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link_ok
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(GAP_TIMEOUT + 1);
  localparam int FW = $clog2(FAILSAFE_CYC + 1);
  localparam logic [HW-1:0] MIN_H  = HW'(MIN_HIGH);
  localparam logic [HW-1:0] MAX_H  = HW'(MAX_HIGH);
  localparam logic [HW-1:0] THR_H  = HW'(CLK_PER_BIT_THRESH);
  localparam logic [LW-1:0] GAP_L  = LW'(GAP_TIMEOUT - 1);
  localparam logic [FW-1:0] FS_MAX = FW'(FAILSAFE_CYC);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [14:0]   shift_q, shift_d;
  logic [10:0]   thr_q, thr_d;
  logic          tel_q, tel_d;
  logic [7:0]    spd_q, spd_d;
  logic          fv_q, fv_d, fe_q, fe_d;
  logic [FW-1:0] fs_q, fs_d;
  logic          link_q, link_d;

  logic        pin_s, rise, fall, bit_v;
  logic [15:0] frame;
  logic [3:0]  crc_exp;

  function automatic logic [7:0] speed_of(input logic [10:0] t);
    logic [10:0] d;
    d = t - 11'd48;
    return (t < 11'd48) ? 8'd0 : d[10:3];
  endfunction

  assign pin_s   = sync_q[1];
  assign rise    = pin_s & ~prev_q;
  assign fall    = ~pin_s & prev_q;
  assign bit_v   = (hcnt_q >= THR_H);
  assign frame   = {shift_q, bit_v};
  // Nibble-wise XOR of the 12-bit value field equals the folded-shift CRC.
  assign crc_exp = frame[15:12] ^ frame[11:8] ^ frame[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      thr_q   <= '0;
      tel_q   <= 1'b0;
      spd_q   <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      fs_q    <= '0;
      link_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], dshotPin};
      prev_q  <= sync_q[1];
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      thr_q   <= thr_d;
      tel_q   <= tel_d;
      spd_q   <= spd_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      fs_q    <= fs_d;
      link_q  <= link_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    thr_d   = thr_q;
    tel_d   = tel_q;
    spd_d   = spd_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    fs_d    = fs_q;
    link_d  = link_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = {{(HW-1){1'b0}}, 1'b1};
        end
      end
      HIGH: begin
        if (fall) begin
          if (hcnt_q < MIN_H || hcnt_q > MAX_H) begin
            fe_d    = 1'b1;
            bcnt_d  = '0;
            state_d = IDLE;
          end else begin
            shift_d = frame[14:0];
            if (bcnt_q == 5'd15) begin
              bcnt_d  = '0;
              state_d = IDLE;
              if (crc_exp == frame[3:0]) begin
                fv_d  = 1'b1;
                thr_d = frame[15:5];
                tel_d = frame[4];
                spd_d = speed_of(frame[15:5]);
              end else begin
                fe_d = 1'b1;
              end
            end else begin
              bcnt_d  = bcnt_q + 5'd1;
              lcnt_d  = '0;
              state_d = LOW;
            end
          end
        end else if (hcnt_q <= MAX_H) begin
          // Stops one past MAX_HIGH so an over-long pulse is still flagged.
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = {{(HW-1){1'b0}}, 1'b1};
        end else if (lcnt_q == GAP_L) begin
          fe_d    = (bcnt_q != 5'd0);
          bcnt_d  = '0;
          state_d = IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fv_d) begin
      fs_d   = '0;
      link_d = 1'b1;
    end else if (fs_q == FS_MAX) begin
      link_d = 1'b0;
      thr_d  = '0;
      tel_d  = 1'b0;
      spd_d  = '0;
    end else begin
      fs_d = fs_q + 1'b1;
    end
  end

  assign throttle    = thr_q;
  assign telem       = tel_q;
  assign outputSpeed = spd_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign link_ok     = link_q;

endmodule

// File: tb/tb_dshot_frame_rx.sv
// Bench for dshot_frame_rx: directed DShot frames plus random frames checked
// against an arithmetic model of throttle/CRC/failsafe behaviour.
module tb_dshot_frame_rx;
  localparam int FS = 2500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pin = 1'b0;
  logic [10:0] throttle;
  logic        telem;
  logic [7:0]  outputSpeed;
  logic        frame_valid, frame_err, link_ok;

  always #5 clk = ~clk;

  dshot_frame_rx #(.FAILSAFE_CYC(FS)) u_dut (
    .clk(clk), .rst_n(rst_n), .dshotPin(pin),
    .throttle(throttle), .telem(telem), .outputSpeed(outputSpeed),
    .frame_valid(frame_valid), .frame_err(frame_err), .link_ok(link_ok)
  );

  int checks = 0, fails = 0;
  int nv = 0, ne = 0, both = 0, cyc = 0;
  int exp_thr = 0, exp_tel = 0, exp_link = 0, have_valid = 0, last_valid = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_valid) nv <= nv + 1;
    if (frame_err) ne <= ne + 1;
    if (frame_valid && frame_err) both <= both + 1;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic int spd(input int t);
    return (t < 48) ? 0 : (t - 48) / 8;
  endfunction

  function automatic int crc_of(input int value);
    return (value ^ (value >> 4) ^ (value >> 8)) & 15;
  endfunction

  task automatic refresh_failsafe();
    if (have_valid == 0 || (cyc - last_valid) > FS) begin
      exp_thr = 0; exp_tel = 0; exp_link = 0;
    end else exp_link = 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_thr"}, int'(throttle), exp_thr);
    chk({tag, "_tel"}, int'(telem), exp_tel);
    chk({tag, "_spd"}, int'(outputSpeed), spd(exp_thr));
    chk({tag, "_link"}, int'(link_ok), exp_link);
  endtask

  task automatic drive_bit(input bit b, input int hi);
    pin = 1'b1;
    repeat (hi) @(negedge clk);
    pin = 1'b0;
  endtask

  // Sends the first n bits of f MSB-first; the line is left low after the last bit.
  task automatic send_bits(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = f[15-i];
      drive_bit(b, b ? 80 : 40);
      if (i < n - 1) repeat (b ? 27 : 67) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] f);
    int fi, ok;
    fi = int'(f);
    send_bits(f, 16);
    repeat (2) @(negedge clk);
    chk({tag, "_early"}, int'(frame_valid | frame_err), 0);
    @(negedge clk);
    ok = (crc_of(fi >> 4) == (fi & 15)) ? 1 : 0;
    if (ok != 0) begin
      exp_thr = fi >> 5; exp_tel = (fi >> 4) & 1;
      have_valid = 1; last_valid = cyc;
    end
    refresh_failsafe();
    chk({tag, "_fv"}, int'(frame_valid), ok);
    chk({tag, "_fe"}, int'(frame_err), 1 - ok);
    check_outputs(tag);
    repeat (300) @(negedge clk);
  endtask

  initial begin
    int ne0, nv0, v;
    logic [15:0] f;

    repeat (3) @(negedge clk);
    refresh_failsafe();
    check_outputs("reset");
    chk("reset_fv", int'(frame_valid), 0);
    chk("reset_fe", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check_frame("f82c6", 16'h82C6);
    check_frame("fffff", 16'hFFFF);
    check_frame("f0606", 16'h0606);
    check_frame("f82c6b", 16'h82C6);
    check_frame("badcrc", 16'h82C7);

    // partial frame then long low gap
    ne0 = ne; nv0 = nv;
    send_bits(16'h82C6, 8);
    repeat (250) @(negedge clk);
    chk("gap_err", ne - ne0, 1);
    chk("gap_nv", nv - nv0, 0);
    check_frame("after_gap", 16'h82C6);

    // short glitch mid-frame, then over-long pulse from idle
    ne0 = ne; nv0 = nv;
    send_bits(16'h82C6, 5);
    repeat (67) @(negedge clk);
    drive_bit(1'b1, 10);
    repeat (100) @(negedge clk);
    chk("glitch_err", ne - ne0, 1);
    drive_bit(1'b1, 120);
    repeat (100) @(negedge clk);
    chk("long_err", ne - ne0, 2);
    chk("glitch_nv", nv - nv0, 0);
    check_frame("after_glitch", 16'h82C6);

    for (int k = 0; k < 12; k++) begin
      v = int'($urandom_range(0, 4095));
      if (k % 2 == 0) f = 16'((v << 4) | crc_of(v));
      else f = 16'((v << 4) | int'($urandom_range(0, 15)));
      check_frame("rand", f);
    end

    // failsafe expiry
    check_frame("pre_fs", 16'hFFFF);
    repeat (FS + 50) @(negedge clk);
    refresh_failsafe();
    check_outputs("failsafe");

    // reset asserted during a high pulse mid-frame
    check_frame("pre_rst", 16'h82C6);
    send_bits(16'h82C6, 8);
    repeat (30) @(negedge clk);
    pin = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    have_valid = 0; exp_thr = 0; exp_tel = 0;
    refresh_failsafe();
    check_outputs("midrst");
    pin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_frame("post_rst", 16'h0606);

    chk("both_strobes", both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
